// File: rtl/lcd_bus_scheduler_pkg.sv
// Shared encodings, default timing and clear/home opcodes for the 4-bit LCD bus scheduler.
package lcd_bus_scheduler_pkg;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_SU_HI = 4'd1,
    ST_PW_HI = 4'd2,
    ST_H_HI  = 4'd3,
    ST_GAP   = 4'd4,
    ST_SU_LO = 4'd5,
    ST_PW_LO = 4'd6,
    ST_H_LO  = 4'd7,
    ST_WAIT  = 4'd8
  } state_t;

  localparam int DEF_T_SU   = 2;
  localparam int DEF_T_PW   = 12;
  localparam int DEF_T_H    = 1;
  localparam int DEF_T_NIB  = 50;
  localparam int DEF_T_BYTE = 2000;
  localparam int DEF_T_LONG = 82000;
  localparam int DEF_CNT_W  = 17;

  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_HOME     = 8'h02;
  localparam logic [7:0] OP_HOME_ALT = 8'h03;

  // Clear/home commands need the long post-write wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] dat);
    return !rs && (dat == OP_CLEAR || dat == OP_HOME || dat == OP_HOME_ALT);
  endfunction

endpackage

// File: rtl/lcd_bus_scheduler_rr_arb2.sv
// Two-port round-robin grant; grant is combinational, last-grant register remembers the winner.
module lcd_rr_arb2 (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_en,
  input  logic [1:0] i_req,
  output logic [1:0] o_gnt
);

  // Reset to "B won last" so A has priority after reset.
  logic r_last_b;

  always_comb begin
    o_gnt = 2'b00;
    if (i_en) begin
      if (i_req == 2'b11) o_gnt = r_last_b ? 2'b01 : 2'b10;
      else                o_gnt = i_req;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)       r_last_b <= 1'b1;
    else if (|o_gnt) r_last_b <= o_gnt[1];
  end

endmodule

// File: rtl/lcd_bus_scheduler.sv
// Arbitrates two byte requesters onto the 4-bit LCD bus and sequences nibble strobes/delays.
// Optional: define LCD_SCHED_LONG_CMD_EN to use T_LONG after clear/home commands.
module lcd_bus_scheduler
  import lcd_bus_scheduler_pkg::*;
#(
  parameter int T_SU   = DEF_T_SU,
  parameter int T_PW   = DEF_T_PW,
  parameter int T_H    = DEF_T_H,
  parameter int T_NIB  = DEF_T_NIB,
  parameter int T_BYTE = DEF_T_BYTE,
  parameter int T_LONG = DEF_T_LONG,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       A_REQ,
  input  logic       A_RS,
  input  logic [7:0] A_DAT,
  output logic       A_ACK,
  input  logic       B_REQ,
  input  logic       B_RS,
  input  logic [7:0] B_DAT,
  output logic       B_ACK,
  output logic       BUSY,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [3:0] SF_D
);

  localparam logic [CNT_W-1:0] C_SU   = CNT_W'(T_SU - 1);
  localparam logic [CNT_W-1:0] C_PW   = CNT_W'(T_PW - 1);
  localparam logic [CNT_W-1:0] C_H    = CNT_W'(T_H - 1);
  localparam logic [CNT_W-1:0] C_NIB  = CNT_W'(T_NIB - 1);
  localparam logic [CNT_W-1:0] C_BYTE = CNT_W'(T_BYTE - 1);
  localparam logic [CNT_W-1:0] C_LONG = CNT_W'(T_LONG - 1);

  state_t           r_state, w_state_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic [1:0]       w_gnt;
  logic             w_idle;
  logic             w_long;
  logic             r_rs;
  logic [7:0]       r_dat;
  logic [3:0]       r_sf_d;
  logic             r_lcd_e;
  logic             r_a_ack, r_b_ack;

  assign w_idle = (r_state == ST_IDLE);

  lcd_rr_arb2 u_arb (
    .i_clk (CLK),
    .i_rst (RST),
    .i_en  (w_idle),
    .i_req ({B_REQ, A_REQ}),
    .o_gnt (w_gnt)
  );

`ifdef LCD_SCHED_LONG_CMD_EN
  assign w_long = is_long_cmd(r_rs, r_dat);
`else
  assign w_long = 1'b0;
`endif

  // Counter is loaded with T-1 on state entry; the state exits on the cycle it reads 0.
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    if (r_state == ST_IDLE) begin
      w_cnt_nx = '0;
      if (|w_gnt) begin
        w_state_nx = ST_SU_HI;
        w_cnt_nx   = C_SU;
      end
    end else if (r_cnt != '0) begin
      w_cnt_nx = r_cnt - CNT_W'(1);
    end else begin
      unique case (r_state)
        ST_SU_HI: begin w_state_nx = ST_PW_HI; w_cnt_nx = C_PW;  end
        ST_PW_HI: begin w_state_nx = ST_H_HI;  w_cnt_nx = C_H;   end
        ST_H_HI:  begin w_state_nx = ST_GAP;   w_cnt_nx = C_NIB; end
        ST_GAP:   begin w_state_nx = ST_SU_LO; w_cnt_nx = C_SU;  end
        ST_SU_LO: begin w_state_nx = ST_PW_LO; w_cnt_nx = C_PW;  end
        ST_PW_LO: begin w_state_nx = ST_H_LO;  w_cnt_nx = C_H;   end
        ST_H_LO:  begin
          w_state_nx = ST_WAIT;
          w_cnt_nx   = w_long ? C_LONG : C_BYTE;
        end
        default:  begin w_state_nx = ST_IDLE;  w_cnt_nx = '0;    end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  // Pins are registered off the next state so E is clean and aligned with PW states.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_rs    <= 1'b0;
      r_dat   <= '0;
      r_sf_d  <= '0;
      r_lcd_e <= 1'b0;
      r_a_ack <= 1'b0;
      r_b_ack <= 1'b0;
    end else begin
      r_a_ack <= w_gnt[0];
      r_b_ack <= w_gnt[1];
      r_lcd_e <= (w_state_nx == ST_PW_HI) || (w_state_nx == ST_PW_LO);
      if (|w_gnt) begin
        r_rs   <= w_gnt[1] ? B_RS : A_RS;
        r_dat  <= w_gnt[1] ? B_DAT : A_DAT;
        r_sf_d <= w_gnt[1] ? B_DAT[7:4] : A_DAT[7:4];
      end else if (r_state == ST_GAP && w_state_nx == ST_SU_LO) begin
        r_sf_d <= r_dat[3:0];
      end
    end
  end

  assign A_ACK  = r_a_ack;
  assign B_ACK  = r_b_ack;
  assign BUSY   = !w_idle;
  assign LCD_RS = r_rs;
  assign LCD_RW = 1'b0;
  assign LCD_E  = r_lcd_e;
  assign SF_D   = r_sf_d;

endmodule
